xlr_dmy1_accel: RTL and testbench

Dummy accelerator for the xbox accelerator slot, exposed to the bench as `xbox_xlr_dmy1`. The host triggers it through the general-purpose host-register interface. It then walks a range of lines in memory 0, computes a wrapping sum of all original 32-bit words, and writes every line back with each word incremented by one. When finished it reports the sum and the line count to the host on the register outputs with a one-cycle valid pulse.

---
 rtl/xlr_dmy1_accel.sv | 154 +++++++++++++++
 tb/tb_xlr_dmy1_accel.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xlr_dmy1_accel.sv
// Dummy xbox accelerator: walks lines of memory 0, sums every 32-bit word and
// writes each line back with all words incremented; reports sum and line count.
module xlr_dmy1_accel #(
    parameter int NUM_MEMS           = 1,
    parameter int LOG2_LINES_PER_MEM = 4
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]      xlr_mem_addr,
    output logic [NUM_MEMS-1:0][255:0]                       xlr_mem_wdata,
    output logic [NUM_MEMS-1:0][31:0]                        xlr_mem_be,
    output logic [NUM_MEMS-1:0]                              xlr_mem_rd,
    output logic [NUM_MEMS-1:0]                              xlr_mem_wr,
    input  logic [NUM_MEMS-1:0][255:0]                       xlr_mem_rdata,
    input  logic [31:0][31:0]                                host_regs,
    input  logic [31:0]                                      host_regs_valid_pulse,
    output logic [31:0][31:0]                                host_regs_data_out,
    output logic [31:0]                                      host_regs_valid_out
);

    localparam int L      = LOG2_LINES_PER_MEM;
    localparam int DATA_W = 32;
    localparam int WORDS  = 8;
    localparam int LINE_W = DATA_W * WORDS;
    localparam int CNT_W  = L + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    idx_q;
    logic [CNT_W-1:0]    n_lines_q;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   sum_q;
    logic [DATA_W-1:0]   n_out_q;
    logic [LINE_W-1:0]   line_p0;

    logic                start;
    logic [CNT_W-1:0]    n_start;
    logic                last_line;
    logic                unused_inputs;

    // Requests beyond the memory depth are processed as a full sweep.
    function automatic logic [CNT_W-1:0] clamp_lines(input logic [31:0] n);
        if (n > 32'(2 ** L))
            return CNT_W'(2 ** L);
        else
            return n[CNT_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] line_sum(input logic [LINE_W-1:0] line);
        logic [DATA_W-1:0] s;
        s = '0;
        for (int k = 0; k < WORDS; k++)
            s = s + line[k*DATA_W +: DATA_W];
        return s;
    endfunction

    function automatic logic [LINE_W-1:0] line_incr(input logic [LINE_W-1:0] line);
        logic [LINE_W-1:0] r;
        r = '0;
        for (int k = 0; k < WORDS; k++)
            r[k*DATA_W +: DATA_W] = line[k*DATA_W +: DATA_W] + DATA_W'(1);
        return r;
    endfunction

    assign start         = host_regs_valid_pulse[0] & host_regs[0][0];
    assign n_start       = clamp_lines(host_regs[1]);
    assign last_line     = ((idx_q + CNT_W'(1)) == n_lines_q);
    assign unused_inputs = ^{host_regs, host_regs_valid_pulse, xlr_mem_rdata};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (n_start == '0) ? S_DONE : S_RD;
            S_RD:   state_d = S_WAIT;
            S_WAIT: state_d = S_WR;
            S_WR:   state_d = last_line ? S_DONE : S_RD;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            n_lines_q <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            n_out_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        idx_q     <= '0;
                        acc_q     <= '0;
                        n_lines_q <= n_start;
                        if (n_start == '0) begin
                            sum_q   <= '0;
                            n_out_q <= '0;
                        end
                    end
                end
                S_WAIT: acc_q <= acc_q + line_sum(xlr_mem_rdata[0]);
                S_WR: begin
                    idx_q <= idx_q + CNT_W'(1);
                    if (last_line) begin
                        sum_q   <= acc_q;
                        n_out_q <= 32'(n_lines_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // p0: read line captured in WAIT, consumed by the write-back in WR
    always_ff @(posedge clk) begin
        if (state_q == S_WAIT)
            line_p0 <= xlr_mem_rdata[0];
    end

    always_comb begin
        xlr_mem_addr        = '0;
        xlr_mem_wdata       = '0;
        xlr_mem_be          = '0;
        xlr_mem_rd          = '0;
        xlr_mem_wr          = '0;
        host_regs_data_out  = '0;
        host_regs_valid_out = '0;

        xlr_mem_rd[0] = (state_q == S_RD);
        xlr_mem_wr[0] = (state_q == S_WR);
        if (state_q == S_RD || state_q == S_WR)
            xlr_mem_addr[0] = idx_q[L-1:0];
        if (state_q == S_WR) begin
            xlr_mem_wdata[0] = line_incr(line_p0);
            xlr_mem_be[0]    = '1;
        end

        host_regs_data_out[0] = sum_q;
        host_regs_data_out[1] = n_out_q;
        if (state_q == S_DONE)
            host_regs_valid_out[1:0] = 2'b11;
    end

endmodule

// File: tb/tb_xlr_dmy1_accel.sv
// Directed bench for xlr_dmy1_accel with a one-cycle-latency memory model.
module tb_xlr_dmy1_accel;

    localparam int NM    = 1;
    localparam int L     = 4;
    localparam int DEPTH = 16;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NM-1:0][L-1:0]        xlr_mem_addr;
    logic [NM-1:0][255:0]        xlr_mem_wdata;
    logic [NM-1:0][31:0]         xlr_mem_be;
    logic [NM-1:0]               xlr_mem_rd;
    logic [NM-1:0]               xlr_mem_wr;
    logic [NM-1:0][255:0]        xlr_mem_rdata;
    logic [31:0][31:0]           host_regs;
    logic [31:0]                 host_regs_valid_pulse;
    logic [31:0][31:0]           host_regs_data_out;
    logic [31:0]                 host_regs_valid_out;

    always #5 clk = ~clk;

    xlr_dmy1_accel #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(L)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .xlr_mem_addr          (xlr_mem_addr),
        .xlr_mem_wdata         (xlr_mem_wdata),
        .xlr_mem_be            (xlr_mem_be),
        .xlr_mem_rd            (xlr_mem_rd),
        .xlr_mem_wr            (xlr_mem_wr),
        .xlr_mem_rdata         (xlr_mem_rdata),
        .host_regs             (host_regs),
        .host_regs_valid_pulse (host_regs_valid_pulse),
        .host_regs_data_out    (host_regs_data_out),
        .host_regs_valid_out   (host_regs_valid_out)
    );

    logic [255:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;
    int rel, rd_cnt, wr_cnt, pulse_cnt, pulse_rel, first_rd, first_wr, viol, strobe_cnt;
    logic [31:0]  p_sum, p_n;
    logic [1:0]   p_vpat;
    logic [255:0] pend;
    bit           pend_v;

    typedef struct {
        logic [31:0]  n;
        int           mode;
        logic [31:0]  exp_sum;
        logic [31:0]  exp_n;
        int           exp_pulse;
        int           exp_lines;
        logic [255:0] exp_l0;
        logic [255:0] exp_l1;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] seq_line(input int s);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'(s + k);
        return r;
    endfunction

    function automatic logic outputs_zero();
        return (xlr_mem_rd == '0) && (xlr_mem_wr == '0) && (xlr_mem_addr == '0) &&
               (xlr_mem_wdata == '0) && (xlr_mem_be == '0) &&
               (host_regs_data_out == '0) && (host_regs_valid_out == '0);
    endfunction

    task automatic fill(input int mode);
        for (int l = 0; l < DEPTH; l++)
            for (int k = 0; k < 8; k++)
                case (mode)
                    0:       mem[l][k*32 +: 32] = 32'd1;
                    1:       mem[l][k*32 +: 32] = 32'(l * 8 + k);
                    default: mem[l][k*32 +: 32] = 32'hFFFF_FFFF;
                endcase
    endtask

    task automatic clear_stats();
        rd_cnt = 0; wr_cnt = 0; pulse_cnt = 0; pulse_rel = -1;
        first_rd = -1; first_wr = -1; viol = 0; strobe_cnt = 0;
        p_sum = '0; p_n = '0; p_vpat = '0;
    endtask

    // One clock: observe outputs mid-cycle, then serve the memory after the edge.
    task automatic step();
        @(negedge clk);
        if (xlr_mem_rd[0] || xlr_mem_wr[0]) strobe_cnt++;
        if (xlr_mem_rd[0] && xlr_mem_wr[0]) viol++;
        if (!xlr_mem_rd[0] && !xlr_mem_wr[0] && xlr_mem_addr[0] != '0) viol++;
        if (!xlr_mem_wr[0] && (xlr_mem_wdata[0] != '0 || xlr_mem_be[0] != '0)) viol++;
        if (xlr_mem_wr[0] && xlr_mem_be[0] != 32'hFFFF_FFFF) viol++;
        if (host_regs_valid_out[31:2] != '0) viol++;
        for (int r = 2; r < 32; r++) if (host_regs_data_out[r] != '0) viol++;
        pend_v = 1'b0;
        if (xlr_mem_rd[0]) begin
            if (xlr_mem_addr[0] != 4'(rd_cnt)) viol++;
            if (first_rd < 0) first_rd = rel;
            rd_cnt++;
            pend   = mem[xlr_mem_addr[0]];
            pend_v = 1'b1;
        end
        if (xlr_mem_wr[0]) begin
            if (xlr_mem_addr[0] != 4'(wr_cnt)) viol++;
            if (first_wr < 0) first_wr = rel;
            wr_cnt++;
            mem[xlr_mem_addr[0]] = xlr_mem_wdata[0];
        end
        if (host_regs_valid_out[1:0] != 2'b00) begin
            pulse_cnt++;
            pulse_rel = rel;
            p_vpat    = host_regs_valid_out[1:0];
            p_sum     = host_regs_data_out[0];
            p_n       = host_regs_data_out[1];
        end
        @(posedge clk);
        #1;
        xlr_mem_rdata[0] = pend_v ? pend : {8{32'hDEAD_BEEF}};
        rel++;
    endtask

    task automatic pulse_start(input logic [31:0] n, input logic [31:0] r0);
        host_regs[0] = r0;
        host_regs[1] = n;
        host_regs_valid_pulse[0] = 1'b1;
        step();
        host_regs_valid_pulse[0] = 1'b0;
        host_regs[0] = '0;
    endtask

    task automatic do_start(input logic [31:0] n);
        rel = 0;
        pulse_start(n, 32'd1);
    endtask

    task automatic wait_pulse(input int budget);
        for (int c = 0; c < budget && pulse_cnt == 0; c++) step();
    endtask

    initial begin
        rst_n = 1'b1;
        host_regs = '0;
        host_regs_valid_pulse = '0;
        xlr_mem_rdata = '0;
        rel = 0;
        clear_stats();
        fill(0);

        vecs[0] = '{32'd1,           0, 32'd8,         32'd1,  4,  1, {8{32'd2}}, {8{32'd1}}};
        vecs[1] = '{32'd2,           1, 32'd120,       32'd2,  7,  2, seq_line(1), seq_line(9)};
        vecs[2] = '{32'd20,          2, 32'hFFFFFF80,  32'd16, 49, 16, 256'd0,    256'd0};
        vecs[3] = '{32'd0,           0, 32'd0,         32'd0,  1,  0, {8{32'd1}}, {8{32'd1}}};
        vecs[4] = '{32'd3,           1, 32'd276,       32'd3,  10, 3, seq_line(1), seq_line(9)};
        vecs[5] = '{32'd16,          1, 32'd8128,      32'd16, 49, 16, seq_line(1), seq_line(9)};
        vecs[6] = '{32'h8000_0000,   2, 32'hFFFFFF80,  32'd16, 49, 16, 256'd0,    256'd0};

        // Reset held while the host tries to start.
        host_regs[0] = 32'd1;
        host_regs[1] = 32'd2;
        host_regs_valid_pulse = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("reset_outputs_zero_c%0d", c), 256'(outputs_zero()), 256'd1);
        end
        host_regs_valid_pulse = '0;
        host_regs = '0;
        rst_n = 1'b0;
        clear_stats();
        for (int c = 0; c < 10; c++) step();
        check("idle_outputs_zero", 256'(outputs_zero()), 256'd1);
        check("idle_no_strobes", 256'(strobe_cnt), 256'd0);
        check("idle_no_pulse", 256'(pulse_cnt), 256'd0);

        // Pulse without the start bit must be ignored.
        clear_stats();
        pulse_start(32'd2, 32'd2);
        for (int c = 0; c < 10; c++) step();
        check("nostart_no_strobes", 256'(strobe_cnt), 256'd0);
        check("nostart_no_pulse", 256'(pulse_cnt), 256'd0);

        for (int v = 0; v < 7; v++) begin
            fill(vecs[v].mode);
            clear_stats();
            do_start(vecs[v].n);
            wait_pulse(60);
            for (int c = 0; c < 3; c++) step();
            check($sformatf("v%0d_pulse_count", v), 256'(pulse_cnt), 256'd1);
            check($sformatf("v%0d_pulse_cycle", v), 256'(pulse_rel), 256'(vecs[v].exp_pulse));
            check($sformatf("v%0d_valid_bits", v), 256'(p_vpat), 256'd3);
            check($sformatf("v%0d_sum", v), 256'(p_sum), 256'(vecs[v].exp_sum));
            check($sformatf("v%0d_lines", v), 256'(p_n), 256'(vecs[v].exp_n));
            check($sformatf("v%0d_rd_count", v), 256'(rd_cnt), 256'(vecs[v].exp_lines));
            check($sformatf("v%0d_wr_count", v), 256'(wr_cnt), 256'(vecs[v].exp_lines));
            check($sformatf("v%0d_mem_line0", v), mem[0], vecs[v].exp_l0);
            check($sformatf("v%0d_mem_line1", v), mem[1], vecs[v].exp_l1);
            check($sformatf("v%0d_protocol", v), 256'(viol), 256'd0);
            check($sformatf("v%0d_sum_held", v), 256'(host_regs_data_out[0]), 256'(vecs[v].exp_sum));
            if (vecs[v].exp_lines > 0) begin
                check($sformatf("v%0d_first_rd", v), 256'(first_rd), 256'd1);
                check($sformatf("v%0d_first_wr", v), 256'(first_wr), 256'd3);
            end
        end

        // A second start while busy must not disturb the run.
        fill(1);
        clear_stats();
        do_start(32'd4);
        while (rel < 5) step();
        pulse_start(32'd1, 32'd1);
        wait_pulse(60);
        for (int c = 0; c < 10; c++) step();
        check("busy_pulse_count", 256'(pulse_cnt), 256'd1);
        check("busy_pulse_cycle", 256'(pulse_rel), 256'd13);
        check("busy_sum", 256'(p_sum), 256'd496);
        check("busy_lines", 256'(p_n), 256'd4);
        check("busy_rd_count", 256'(rd_cnt), 256'd4);
        check("busy_protocol", 256'(viol), 256'd0);

        // Reset in cycle 5 aborts the run before line 1 is written.
        fill(1);
        clear_stats();
        do_start(32'd4);
        while (rel < 5) step();
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        begin
            int s0;
            s0 = strobe_cnt;
            for (int c = 0; c < 20; c++) step();
            check("abort_no_strobes", 256'(strobe_cnt - s0), 256'd0);
        end
        check("abort_no_pulse", 256'(pulse_cnt), 256'd0);
        check("abort_outputs_zero", 256'(outputs_zero()), 256'd1);
        check("abort_line0_written", mem[0], seq_line(1));
        check("abort_line1_untouched", mem[1], seq_line(8));

        fill(1);
        clear_stats();
        do_start(32'd2);
        wait_pulse(60);
        step();
        check("restart_pulse_cycle", 256'(pulse_rel), 256'd7);
        check("restart_sum", 256'(p_sum), 256'd120);
        check("restart_lines", 256'(p_n), 256'd2);
        check("restart_mem_line1", mem[1], seq_line(9));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
